mem_excep_unit: RTL

//  MEM-stage exception collector sitting directly upstream of cp0. Merges exception flags carried down
//  the pipe with MEM-stage address-alignment checks and synchronised hardware/timer interrupts, picks the

---
 rtl/mem_excep_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_excep_unit.sv
// MEM-stage exception collector: merges pipe flags, alignment faults and interrupts into one cause for cp0.
// Latency: cause/pc/addr/delay-slot registered 1 cycle after the MEM cycle; mem_kill_o is combinational.
// Backpressure: none; after a cause is sent, all MEM ops are killed until flush_i arrives or the WAIT timeout expires.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   mem_valid_i .. mem_addr_i       MEM-stage instruction: valid, pc, delay slot, upstream flags, load/store, size, address
//   cp0_status_i                    Status register (IM[15:8], EXL[1], IE[0])
//   int_i, timer_int_i              async hardware interrupts, synchronous timer interrupt
//   flush_i                         cp0 has accepted the exception / ERET
//   excep_type_o .. excep_delayslot_o  registered one-hot cause, pc, bad address, delay-slot flag
//   mem_kill_o                      suppress the data-RAM access in this cycle
//   err_o                           one-cycle pulse when cp0 never answered with flush_i
module mem_excep_unit #(
   parameter int SYNC_STAGES   = 2,
   parameter int FLUSH_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [31:0] mem_excep_i,
   input  logic        mem_is_load_i,
   input  logic        mem_is_store_i,
   input  logic [1:0]  mem_size_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] cp0_status_i,
   input  logic [5:0]  int_i,
   input  logic        timer_int_i,
   input  logic        flush_i,
   output logic [31:0] excep_type_o,
   output logic [31:0] excep_pc_o,
   output logic [31:0] excep_addr_o,
   output logic        excep_delayslot_o,
   output logic        mem_kill_o,
   output logic        err_o
);

   localparam int         SYNC_W    = 6 * SYNC_STAGES;
   localparam logic [3:0] TIMEOUT_L = 4'(FLUSH_TIMEOUT);

   typedef enum logic {ST_RUN, ST_WAIT} state_t;

   state_t              state_q, state_d;
   logic [SYNC_W-1:0]   sync_q, sync_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [31:0]         type_q, type_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         addr_q, addr_d;
   logic                ds_q, ds_d;

   logic [5:0]          int_s;
   logic [5:0]          int_lines;
   logic                int_req;
   logic                misalign;
   logic [31:0]         win;
   logic [3:0]          cnt_inc;

   // Status bits without a consumer here (software interrupts IM[1:0], reserved fields)
   // and upstream flag bits that this stage does not recognise.
   logic                unused_bits;
   assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[9:2], mem_excep_i[26:1]};

   // Oldest stage of the chain is the synchronised view of int_i.
   assign int_s     = sync_q[SYNC_W-1 -: 6];
   // The timer shares IM[7] with hardware line 5.
   assign int_lines = {timer_int_i | int_s[5], int_s[4:0]};
   assign int_req   = cp0_status_i[0] & ~cp0_status_i[1] & (|(cp0_status_i[15:10] & int_lines));

   // Byte accesses are never misaligned; size 3 is treated as a word.
   assign misalign  = ((mem_size_i == 2'd1) & mem_addr_i[0]) |
                      (mem_size_i[1] & (mem_addr_i[1:0] != 2'b00));

   assign cnt_inc   = cnt_q + 4'd1;

   // Priority pick; the result is one-hot or zero.
   always_comb begin
      win = 32'h0;
      if ((state_q == ST_RUN) && mem_valid_i) begin
         if (int_req)                               win[1]  = 1'b1;
         else if (mem_excep_i[31])                  win[31] = 1'b1;
         else if (mem_excep_i[30])                  win[30] = 1'b1;
         else if (mem_excep_i[29])                  win[29] = 1'b1;
         else if (mem_excep_i[28])                  win[28] = 1'b1;
         else if (mem_excep_i[27])                  win[27] = 1'b1;
         else if (mem_is_load_i & misalign)         win[26] = 1'b1;
         else if (mem_is_store_i & misalign)        win[25] = 1'b1;
         else if (mem_excep_i[0])                   win[0]  = 1'b1;
      end
   end

   // ERET alone performs no memory access, so there is nothing to kill for it.
   assign mem_kill_o = (state_q == ST_WAIT) | ((|win) & ~win[0]);

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[SYNC_W-7:0], int_i};
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      type_d  = 32'h0;
      pc_d    = 32'h0;
      addr_d  = 32'h0;
      ds_d    = 1'b0;
      case (state_q)
         ST_RUN: begin
            // flush_i is meaningless here: nothing is outstanding.
            cnt_d = 4'd0;
            if (|win) begin
               type_d  = win;
               pc_d    = mem_pc_i;
               ds_d    = mem_in_delayslot_i;
               if (win[26] | win[25]) addr_d = mem_addr_i;
               else if (win[31])      addr_d = mem_pc_i;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Causes seen while waiting are dropped; the pipe is being flushed anyway.
            if (flush_i) begin
               state_d = ST_RUN;
               cnt_d   = 4'd0;
            end else if (cnt_inc == TIMEOUT_L) begin
               // cp0 never acknowledged: give up so the core cannot lock, and flag it.
               state_d = ST_RUN;
               cnt_d   = 4'd0;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         sync_q  <= '0;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         type_q  <= 32'h0;
         pc_q    <= 32'h0;
         addr_q  <= 32'h0;
         ds_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         type_q  <= type_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ds_q    <= ds_d;
      end
   end

   assign excep_type_o      = type_q;
   assign excep_pc_o        = pc_q;
   assign excep_addr_o      = addr_q;
   assign excep_delayslot_o = ds_q;
   assign err_o             = err_q;

endmodule
